// File: rtl/lv_owt_access_rsp.sv
`default_nettype none
// ============================================================================
// Module   : lv_owt_access_rsp
// Brief    : LV-side responder that turns a held SPI register write/read
//            request into a CRC-protected one-wire-transfer frame, waits for
//            the HV echo/reply, retries bad or missing replies, and returns a
//            single wack/rack pulse. Good read replies update the LV mirror.
// Revision : 1.0 - initial release
// ============================================================================
module lv_owt_access_rsp #(
    parameter int REG_AW      = 7,
    parameter int REG_DW      = 8,
    parameter int REG_CRC_W   = 8,
    parameter int TIMEOUT_CYC = 1023,
    parameter int RETRY_NUM   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    // request side from the register access arbiter
    input  logic                 i_spi_owt_wr_req,
    input  logic                 i_spi_owt_rd_req,
    input  logic [REG_AW-1:0]    i_spi_owt_addr,
    input  logic [REG_DW-1:0]    i_spi_owt_data,
    output logic                 o_owt_spi_wack,
    output logic                 o_owt_spi_rack,
    output logic                 o_owt_fail,
    output logic                 o_owt_busy,
    // transmit frame towards the OWT PHY
    output logic                 o_owt_tx_req,
    output logic                 o_owt_tx_wr,
    output logic [REG_AW-1:0]    o_owt_tx_addr,
    output logic [REG_DW-1:0]    o_owt_tx_data,
    output logic [REG_CRC_W-1:0] o_owt_tx_crc,
    input  logic                 i_owt_tx_ack,
    // reply frame from the OWT PHY
    input  logic                 i_owt_rx_vld,
    input  logic [REG_AW-1:0]    i_owt_rx_addr,
    input  logic [REG_DW-1:0]    i_owt_rx_data,
    input  logic [REG_CRC_W-1:0] i_owt_rx_crc,
    input  logic                 i_owt_rx_err,
    // LV mirror register bank update
    output logic                 o_owt_reg_wen,
    output logic [REG_AW-1:0]    o_owt_reg_addr,
    output logic [REG_DW-1:0]    o_owt_reg_wdata,
    output logic                 o_owt_timeout
);

    // frame payload is {wr, addr, data}
    localparam int FRAME_W = 1 + REG_AW + REG_DW;
    localparam int TMO_W   = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int RTY_W   = (RETRY_NUM < 1) ? 1 : $clog2(RETRY_NUM + 1);

    localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(8'h07);
    localparam logic [REG_CRC_W-1:0] CRC_INIT = '1;

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(RETRY_NUM);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND     = 3'd1;
    localparam logic [2:0] WAIT_RSP = 3'd2;
    localparam logic [2:0] ACK      = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;

    // Bit-serial CRC, MSB of the payload first, no reflection or final xor.
    function automatic logic [REG_CRC_W-1:0] crc_calc(input logic [FRAME_W-1:0] msg);
        logic [REG_CRC_W-1:0] c;
        logic                 fb;
        c = CRC_INIT;
        for (int i = FRAME_W - 1; i >= 0; i--) begin
            fb = c[REG_CRC_W-1] ^ msg[i];
            c  = {c[REG_CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    logic [2:0]           state;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [RTY_W-1:0]     retry_cnt;

    logic                 req_any;
    logic [REG_DW-1:0]    cap_data;
    logic [REG_CRC_W-1:0] cap_crc;
    logic [REG_CRC_W-1:0] rx_crc_exp;
    logic                 rx_good;
    logic                 timeout_hit;
    logic                 attempt_fail;

    // Frame build for a new capture and qualification of the reply frame.
    always_comb begin
        req_any      = i_spi_owt_wr_req | i_spi_owt_rd_req;
        // reads carry an all-zero data field on the wire
        cap_data     = i_spi_owt_wr_req ? i_spi_owt_data : '0;
        cap_crc      = crc_calc({i_spi_owt_wr_req, i_spi_owt_addr, cap_data});
        // reply CRC is checked with the frame type of the outstanding request
        rx_crc_exp   = crc_calc({o_owt_tx_wr, i_owt_rx_addr, i_owt_rx_data});
        rx_good      = i_owt_rx_vld & ~i_owt_rx_err
                     & (i_owt_rx_addr == o_owt_tx_addr)
                     & (i_owt_rx_crc == rx_crc_exp)
                     & (~o_owt_tx_wr | (i_owt_rx_data == o_owt_tx_data));
        timeout_hit  = (tmo_cnt == TMO_LAST);
        // a good reply arriving in the timeout cycle still counts as good
        attempt_fail = ~rx_good & (i_owt_rx_vld | timeout_hit);
    end

    // Transaction FSM; all outputs are registered here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            retry_cnt       <= '0;
            o_owt_spi_wack  <= 1'b0;
            o_owt_spi_rack  <= 1'b0;
            o_owt_fail      <= 1'b0;
            o_owt_busy      <= 1'b0;
            o_owt_tx_req    <= 1'b0;
            o_owt_tx_wr     <= 1'b0;
            o_owt_tx_addr   <= '0;
            o_owt_tx_data   <= '0;
            o_owt_tx_crc    <= '0;
            o_owt_reg_wen   <= 1'b0;
            o_owt_reg_addr  <= '0;
            o_owt_reg_wdata <= '0;
            o_owt_timeout   <= 1'b0;
        end else begin
            // single-cycle strobes fall back to 0 unless set below
            o_owt_spi_wack <= 1'b0;
            o_owt_spi_rack <= 1'b0;
            o_owt_fail     <= 1'b0;
            o_owt_reg_wen  <= 1'b0;
            o_owt_timeout  <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_any) begin
                        // write wins when both requests are raised together
                        o_owt_tx_wr   <= i_spi_owt_wr_req;
                        o_owt_tx_addr <= i_spi_owt_addr;
                        o_owt_tx_data <= cap_data;
                        o_owt_tx_crc  <= cap_crc;
                        o_owt_tx_req  <= 1'b1;
                        o_owt_busy    <= 1'b1;
                        retry_cnt     <= '0;
                        state         <= SEND;
                    end
                end

                SEND: begin
                    if (i_owt_tx_ack) begin
                        o_owt_tx_req <= 1'b0;
                        tmo_cnt      <= '0;
                        state        <= WAIT_RSP;
                    end
                end

                WAIT_RSP: begin
                    if (rx_good) begin
                        o_owt_spi_wack <= o_owt_tx_wr;
                        o_owt_spi_rack <= ~o_owt_tx_wr;
                        if (!o_owt_tx_wr) begin
                            o_owt_reg_wen   <= 1'b1;
                            o_owt_reg_addr  <= o_owt_tx_addr;
                            o_owt_reg_wdata <= i_owt_rx_data;
                        end
                        state <= ACK;
                    end else if (attempt_fail) begin
                        if (retry_cnt < RETRY_MAX) begin
                            // resend the unchanged frame
                            retry_cnt    <= retry_cnt + 1'b1;
                            o_owt_tx_req <= 1'b1;
                            state        <= SEND;
                        end else begin
                            o_owt_timeout  <= 1'b1;
                            o_owt_fail     <= 1'b1;
                            o_owt_spi_wack <= o_owt_tx_wr;
                            o_owt_spi_rack <= ~o_owt_tx_wr;
                            state          <= ACK;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ACK: begin
                    retry_cnt <= '0;
                    state     <= HOLD;
                end

                HOLD: begin
                    // a request still held after the ack must not restart
                    if (!req_any) begin
                        o_owt_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    o_owt_tx_req <= 1'b0;
                    o_owt_busy   <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lv_owt_access_rsp.sv
`default_nettype none
// ============================================================================
// Module   : tb_lv_owt_access_rsp
// Brief    : Self-checking bench for lv_owt_access_rsp with an OWT PHY/HV
//            responder model and a transaction-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lv_owt_access_rsp;

    localparam int AW      = 7;
    localparam int DW      = 8;
    localparam int CW      = 8;
    localparam int TO      = 15;
    localparam int RN      = 2;
    localparam int MAX_ATT = RN + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req, rd_req;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wack, rack, fail, busy;
    logic          tx_req, tx_wr;
    logic [AW-1:0] tx_addr;
    logic [DW-1:0] tx_data;
    logic [CW-1:0] tx_crc;
    logic          tx_ack;
    logic          rx_vld, rx_err;
    logic [AW-1:0] rx_addr;
    logic [DW-1:0] rx_data;
    logic [CW-1:0] rx_crc;
    logic          reg_wen;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          tmo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lv_owt_access_rsp #(
        .REG_AW(AW), .REG_DW(DW), .REG_CRC_W(CW), .TIMEOUT_CYC(TO), .RETRY_NUM(RN)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_spi_owt_wr_req(wr_req), .i_spi_owt_rd_req(rd_req),
        .i_spi_owt_addr(addr), .i_spi_owt_data(data),
        .o_owt_spi_wack(wack), .o_owt_spi_rack(rack), .o_owt_fail(fail), .o_owt_busy(busy),
        .o_owt_tx_req(tx_req), .o_owt_tx_wr(tx_wr), .o_owt_tx_addr(tx_addr),
        .o_owt_tx_data(tx_data), .o_owt_tx_crc(tx_crc), .i_owt_tx_ack(tx_ack),
        .i_owt_rx_vld(rx_vld), .i_owt_rx_addr(rx_addr), .i_owt_rx_data(rx_data),
        .i_owt_rx_crc(rx_crc), .i_owt_rx_err(rx_err),
        .o_owt_reg_wen(reg_wen), .o_owt_reg_addr(reg_addr), .o_owt_reg_wdata(reg_wdata),
        .o_owt_timeout(tmo)
    );

    // CRC-8, poly 0x07, init 0xFF, MSB-first over the 16-bit {wr, addr, data} payload
    function automatic logic [7:0] crc8(input logic [15:0] m);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 15; i >= 0; i--) begin
            if (c[7] ^ m[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // ---------------- output monitor (samples on the falling edge) ----------
    int            n_frames, n_wack, n_rack, n_wen, n_tmo, n_wen_rack;
    logic          last_fail;
    logic [AW-1:0] wen_addr;
    logic [DW-1:0] wen_data;
    logic          prev_tx_req = 1'b0;

    always @(negedge clk) begin
        if (tx_req && !prev_tx_req) n_frames++;
        prev_tx_req = tx_req;
        if (wack) n_wack++;
        if (rack) n_rack++;
        if (wack || rack) last_fail = fail;
        if (reg_wen) begin
            n_wen++;
            wen_addr = reg_addr;
            wen_data = reg_wdata;
            if (rack) n_wen_rack++;
        end
        if (tmo) n_tmo++;
    end

    task automatic clr_mon();
        n_frames = 0; n_wack = 0; n_rack = 0; n_wen = 0; n_tmo = 0; n_wen_rack = 0;
        last_fail = 1'bx; wen_addr = 'x; wen_data = 'x;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- PHY / HV responder model ------------------------------
    logic          f_wr;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_data;
    logic [CW-1:0] f_crc;
    int            frame_diff;

    task automatic wait_tx_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Serves up to MAX_ATT frames. The first n_bad attempts get a bad reply of
    // the given kind (0 silent, 1 bad crc, 2 rx_err, 3 wrong addr, 4 wrong
    // data; 5 picks one at random per attempt); the next one is answered well.
    task automatic phy_serve(input logic m_wr, input logic [AW-1:0] m_addr,
                             input logic [DW-1:0] m_data, input int n_bad,
                             input int kind, input logic [DW-1:0] rdata,
                             output bit lost);
        bit            ok;
        int            k;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic [CW-1:0] rc;
        lost       = 1'b0;
        frame_diff = 0;
        for (int att = 0; att < MAX_ATT; att++) begin
            wait_tx_req(ok);
            if (!ok) begin
                lost = 1'b1;
                return;
            end
            if (att == 0) begin
                f_wr = tx_wr; f_addr = tx_addr; f_data = tx_data; f_crc = tx_crc;
            end else if ({tx_wr, tx_addr, tx_data, tx_crc} !== {f_wr, f_addr, f_data, f_crc}) begin
                frame_diff++;
            end
            tick($urandom_range(0, 3));
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
            if (att < n_bad) k = (kind > 4) ? int'($urandom_range(0, 4)) : kind;
            else             k = -1;
            if (k == 0) continue;
            tick($urandom_range(0, 10));
            ra = m_addr;
            rd = m_wr ? m_data : rdata;
            if (k == 3) ra = ra ^ 7'h01;
            if (k == 4 && m_wr) rd = rd ^ 8'h01;
            rc = crc8({m_wr, ra, rd});
            if (k == 1 || (k == 4 && !m_wr)) rc = rc ^ 8'h01;
            rx_vld = 1'b1; rx_addr = ra; rx_data = rd; rx_crc = rc; rx_err = (k == 2);
            tick();
            rx_vld = 1'b0; rx_err = 1'b0; rx_addr = $urandom; rx_data = $urandom; rx_crc = $urandom;
            if (k < 0) return;
        end
    endtask

    // Full transaction: raise request(s), scramble inputs after capture, serve
    // the PHY side, wait for the ack, keep the request `hold` cycles, drop it.
    bit hold_busy, busy_end;
    int hold_frames;

    task automatic run_txn(input logic w, input logic r, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int n_bad, input int kind,
                           input logic [DW-1:0] rdata, input int hold, output bit lost);
        bit got;
        clr_mon();
        wr_req = w; rd_req = r; addr = a; data = d;
        tick();
        addr = $urandom; data = $urandom;
        phy_serve(w, a, d, n_bad, kind, rdata, lost);
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (n_wack + n_rack > 0) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) lost = 1'b1;
        tick(hold);
        hold_busy   = busy;
        hold_frames = n_frames;
        wr_req = 1'b0; rd_req = 1'b0;
        tick(3);
        busy_end = busy;
    endtask

    // ---------------- tests ---------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        wr_req = 0; rd_req = 0; addr = 0; data = 0; tx_ack = 0;
        rx_vld = 0; rx_err = 0; rx_addr = 0; rx_data = 0; rx_crc = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({wack, rack, fail, busy, tx_req, tx_wr, tx_addr, tx_data, tx_crc, reg_wen,
             reg_addr, reg_wdata, tmo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: outputs not all zero while in reset");
        end
        tick();
        rst_n = 1'b1;
        tick(3);
        checks++;
        if ({busy, tx_req} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy/tx_req got %b want 00", {busy, tx_req});
        end
    endtask

    task automatic test_write();
        bit lost;
        run_txn(1'b1, 1'b0, 7'h41, 8'h5A, 0, 0, 8'h00, 0, lost);
        checks++; if (lost) begin errors++; $display("FAIL wr_lost: transaction stalled"); end
        checks++; if (n_wack !== 1 || n_rack !== 0) begin errors++; $display("FAIL wr_ack: wack %0d rack %0d want 1 0", n_wack, n_rack); end
        checks++; if (last_fail !== 1'b0) begin errors++; $display("FAIL wr_fail: got %b want 0", last_fail); end
        checks++; if (n_wen !== 0) begin errors++; $display("FAIL wr_no_wen: got %0d want 0", n_wen); end
        checks++; if ({f_wr, f_addr, f_data} !== {1'b1, 7'h41, 8'h5A}) begin errors++; $display("FAIL wr_frame: got %h want %h", {f_wr, f_addr, f_data}, {1'b1, 7'h41, 8'h5A}); end
        checks++; if (f_crc !== crc8({1'b1, 7'h41, 8'h5A})) begin errors++; $display("FAIL wr_crc: got %h want %h", f_crc, crc8({1'b1, 7'h41, 8'h5A})); end
        checks++; if (n_frames !== 1) begin errors++; $display("FAIL wr_frames: got %0d want 1", n_frames); end
        checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b want 0", busy_end); end
    endtask

    task automatic test_read();
        bit lost;
        run_txn(1'b0, 1'b1, 7'h0C, 8'h77, 0, 0, 8'hA5, 0, lost);
        checks++; if (lost) begin errors++; $display("FAIL rd_lost: transaction stalled"); end
        checks++; if (n_rack !== 1 || n_wack !== 0) begin errors++; $display("FAIL rd_ack: rack %0d wack %0d want 1 0", n_rack, n_wack); end
        checks++; if (n_wen !== 1 || n_wen_rack !== 1) begin errors++; $display("FAIL rd_wen: wen %0d with_rack %0d want 1 1", n_wen, n_wen_rack); end
        checks++; if ({wen_addr, wen_data} !== {7'h0C, 8'hA5}) begin errors++; $display("FAIL rd_mirror: got %h want %h", {wen_addr, wen_data}, {7'h0C, 8'hA5}); end
        checks++; if ({f_wr, f_addr, f_data, f_crc} !== {1'b0, 7'h0C, 8'h00, crc8({1'b0, 7'h0C, 8'h00})}) begin errors++; $display("FAIL rd_frame: got %h", {f_wr, f_addr, f_data, f_crc}); end
        checks++; if (last_fail !== 1'b0) begin errors++; $display("FAIL rd_fail: got %b want 0", last_fail); end
    endtask

    task automatic test_retry();
        bit lost;
        run_txn(1'b0, 1'b1, 7'h45, 8'h00, 1, 1, 8'h3C, 0, lost);
        checks++; if (lost) begin errors++; $display("FAIL retry_lost: transaction stalled"); end
        checks++; if (n_frames !== 2) begin errors++; $display("FAIL retry_frames: got %0d want 2", n_frames); end
        checks++; if (frame_diff !== 0) begin errors++; $display("FAIL retry_same_frame: %0d resent frames differ, want 0", frame_diff); end
        checks++; if (n_rack !== 1 || last_fail !== 1'b0 || n_tmo !== 0) begin errors++; $display("FAIL retry_ack: rack %0d fail %b tmo %0d want 1 0 0", n_rack, last_fail, n_tmo); end
        checks++; if (n_wen !== 1 || wen_data !== 8'h3C) begin errors++; $display("FAIL retry_wen: wen %0d data %h want 1 3c", n_wen, wen_data); end
    endtask

    task automatic test_timeout();
        bit lost;
        run_txn(1'b0, 1'b1, 7'h2B, 8'h00, MAX_ATT, 0, 8'h00, 0, lost);
        checks++; if (lost) begin errors++; $display("FAIL tmo_lost: transaction stalled"); end
        checks++; if (n_frames !== MAX_ATT) begin errors++; $display("FAIL tmo_frames: got %0d want %0d", n_frames, MAX_ATT); end
        checks++; if (n_tmo !== 1) begin errors++; $display("FAIL tmo_pulse: got %0d want 1", n_tmo); end
        checks++; if (n_rack !== 1 || last_fail !== 1'b1) begin errors++; $display("FAIL tmo_ack: rack %0d fail %b want 1 1", n_rack, last_fail); end
        checks++; if (n_wen !== 0) begin errors++; $display("FAIL tmo_no_wen: got %0d want 0", n_wen); end
    endtask

    task automatic test_both();
        bit lost;
        run_txn(1'b1, 1'b1, 7'h12, 8'hC3, 0, 0, 8'h00, 5, lost);
        checks++; if (lost) begin errors++; $display("FAIL both_lost: transaction stalled"); end
        checks++; if (n_wack !== 1 || n_rack !== 0 || f_wr !== 1'b1) begin errors++; $display("FAIL both_write_wins: wack %0d rack %0d tx_wr %b want 1 0 1", n_wack, n_rack, f_wr); end
        checks++; if (hold_frames !== 1 || hold_busy !== 1'b1) begin errors++; $display("FAIL both_hold: frames %0d busy %b want 1 1", hold_frames, hold_busy); end
        checks++; if (n_frames !== 1 || busy_end !== 1'b0) begin errors++; $display("FAIL both_release: frames %0d busy %b want 1 0", n_frames, busy_end); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr_mon();
        rd_req = 1'b1; addr = 7'h33;
        wait_tx_req(ok);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({wack, rack, fail, busy, tx_req, tx_wr, tx_addr, tx_data, tx_crc, reg_wen,
             reg_addr, reg_wdata, tmo} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: outputs not all zero after async reset");
        end
        rd_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
        rx_vld = 1'b1; rx_addr = 7'h33; rx_data = 8'h99; rx_crc = crc8({1'b0, 7'h33, 8'h99});
        tick();
        rx_vld = 1'b0;
        tick(20);
        checks++;
        if (n_rack !== 0 || n_wack !== 0 || n_wen !== 0 || n_frames !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: rack %0d wack %0d wen %0d frames %0d busy %b want 0 0 0 1 0",
                     n_rack, n_wack, n_wen, n_frames, busy);
        end
    endtask

    task automatic test_random();
        bit            lost, w, r, e_fail;
        int            sel, n_bad, e_frames;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rdv;
        for (int t = 0; t < 12; t++) begin
            sel   = $urandom_range(0, 2);
            w     = (sel != 1);
            r     = (sel != 0);
            a     = $urandom;
            d     = $urandom;
            rdv   = $urandom;
            n_bad = $urandom_range(0, MAX_ATT + 1);
            run_txn(w, r, a, d, n_bad, 5, rdv, $urandom_range(0, 3), lost);
            // transaction-level expectations
            e_fail   = (n_bad >= MAX_ATT);
            e_frames = e_fail ? MAX_ATT : n_bad + 1;
            checks++;
            if (lost || n_frames !== e_frames || n_wack !== int'(w) || n_rack !== int'(!w)
                || last_fail !== e_fail || n_tmo !== int'(e_fail)) begin
                errors++;
                $display("FAIL rand_txn%0d: lost %b frames %0d/%0d wack %0d rack %0d fail %b/%b tmo %0d",
                         t, lost, n_frames, e_frames, n_wack, n_rack, last_fail, e_fail, n_tmo);
            end
            checks++;
            if ({f_wr, f_addr, f_data, f_crc} !== {w, a, (w ? d : 8'h00), crc8({w, a, (w ? d : 8'h00)})}) begin
                errors++;
                $display("FAIL rand_frame%0d: got %h want %h", t, {f_wr, f_addr, f_data, f_crc},
                         {w, a, (w ? d : 8'h00), crc8({w, a, (w ? d : 8'h00)})});
            end
            checks++;
            if (!w && !e_fail) begin
                if (n_wen !== 1 || {wen_addr, wen_data} !== {a, rdv}) begin
                    errors++;
                    $display("FAIL rand_mirror%0d: wen %0d got %h want %h", t, n_wen, {wen_addr, wen_data}, {a, rdv});
                end
            end else if (n_wen !== 0) begin
                errors++;
                $display("FAIL rand_no_wen%0d: got %0d want 0", t, n_wen);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_retry();
        test_timeout();
        test_both();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
